// File: rtl/riscv_pkg.sv
// Shared constants and the fetch buffer entry type used by the fetch stage.
package riscv_pkg;

    localparam int CPU_WIDTH = 32;
    localparam logic [CPU_WIDTH-1:0] RESET_PC = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;
    localparam logic [CPU_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [CPU_WIDTH-1:0] pc;
        logic [CPU_WIDTH-1:0] data;
        logic                 filled;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_buffer.sv
// In-order instruction ring buffer: entries are claimed at request time,
// filled by responses in order, and drained from the head.
module riscv_fetch_buffer
    import riscv_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    localparam int PTR_W = $clog2(BUF_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 alloc_en,
    input  logic [CPU_WIDTH-1:0] alloc_pc,
    input  logic                 fill_en,
    input  logic [CPU_WIDTH-1:0] fill_data,
    input  logic                 rd_en,
    output fetch_entry_t         head,
    output logic [PTR_W-1:0]     count,
    output logic [PTR_W-1:0]     unfilled
);

    localparam int IDX_W = PTR_W - 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] r_alloc_ptr;
    logic [PTR_W-1:0] r_fill_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    fetch_entry_t     r_entries [BUF_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (alloc_en) r_alloc_ptr <= r_alloc_ptr + PTR_W'(1);
            if (fill_en)  r_fill_ptr  <= r_fill_ptr + PTR_W'(1);
            if (rd_en)    r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
            // Alloc, fill and read always target distinct entries in one cycle.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (alloc_en && r_alloc_ptr[IDX_W-1:0] == IDX_W'(i)) begin
                    r_entries[i] <= '{pc: alloc_pc, data: '0, filled: 1'b0};
                end else if (fill_en && r_fill_ptr[IDX_W-1:0] == IDX_W'(i)) begin
                    r_entries[i].data   <= fill_data;
                    r_entries[i].filled <= 1'b1;
                end else if (rd_en && r_rd_ptr[IDX_W-1:0] == IDX_W'(i)) begin
                    r_entries[i].filled <= 1'b0;
                end
            end
        end
    end

    assign head     = r_entries[r_rd_ptr[IDX_W-1:0]];
    assign count    = r_alloc_ptr - r_rd_ptr;
    assign unfilled = r_alloc_ptr - r_fill_ptr;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: PC, in-order memory requests, response buffering,
// redirect flush and discard of responses belonging to flushed requests.
module riscv_fetch #(
    parameter int CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] imem_rsp_data,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [CPU_WIDTH-1:0] instr,
    output logic [CPU_WIDTH-1:0] instr_pc
);
    import riscv_pkg::*;

    localparam int PTR_W  = $clog2(BUF_DEPTH) + 1;
    localparam int DROP_W = 8;
    localparam logic [PTR_W-1:0] FULL = PTR_W'(BUF_DEPTH);

    logic [CPU_WIDTH-1:0] r_pc;
    logic [DROP_W-1:0]    r_drop_cnt;
    logic [DROP_W-1:0]    w_drop_total;
    logic [DROP_W-1:0]    w_drop_next;
    logic                 w_req_fire;
    logic                 w_fill_en;
    logic                 w_rd_en;
    logic [PTR_W-1:0]     w_count;
    logic [PTR_W-1:0]     w_unfilled;
    fetch_entry_t         w_head;
    logic                 w_unused_bits;

    assign w_unused_bits = ^redirect_pc[1:0];

    // Gating with rst keeps the request low during reset without a cycle of delay after release.
    assign imem_req_valid = ~rst & (w_count < FULL) & ~redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;
    assign w_fill_en      = imem_rsp_valid & ~redirect_valid & (r_drop_cnt == '0) & (w_unfilled != '0);
    assign w_rd_en        = instr_valid & instr_ready;

    assign instr_valid = w_head.filled;
    assign instr       = w_head.data;
    assign instr_pc    = w_head.pc;

    // A second redirect while drops are pending must keep the earlier ones counted too.
    always_comb begin
        w_drop_total = r_drop_cnt + DROP_W'(w_unfilled);
        w_drop_next  = r_drop_cnt;
        if (redirect_valid) begin
            if (imem_rsp_valid && w_drop_total != '0) w_drop_next = w_drop_total - DROP_W'(1);
            else                                      w_drop_next = w_drop_total;
        end else if (imem_rsp_valid && r_drop_cnt != '0) begin
            w_drop_next = r_drop_cnt - DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_next;
            if (redirect_valid)  r_pc <= {redirect_pc[CPU_WIDTH-1:2], 2'b00};
            else if (w_req_fire) r_pc <= r_pc + CPU_WIDTH'(INSTR_BYTES);
        end
    end

    riscv_fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .alloc_en  (w_req_fire),
        .alloc_pc  (r_pc),
        .fill_en   (w_fill_en),
        .fill_data (imem_rsp_data),
        .rd_en     (w_rd_en),
        .head      (w_head),
        .count     (w_count),
        .unfilled  (w_unfilled)
    );

    // A response with nothing outstanding is a memory protocol error.
    assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && r_drop_cnt == '0 && w_unfilled == '0));

endmodule

// File: tb/tb_riscv_fetch.sv
// Randomized and directed bench for riscv_fetch against a queue-based fetch model.
module tb_riscv_fetch;

    localparam int DEPTH = 4;
    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    riscv_fetch #(
        .CPU_WIDTH (32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          arrived;
    } mentry_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mrsp_t;

    mentry_t     mq[$];
    mrsp_t       pend[$];
    logic [31:0] m_pc = '0;
    int          epoch = 0;
    int          rsp_epoch = -1;
    int          last_due = 0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          dut_fires = 0;
    int          lat_min = 1, lat_max = 1;
    int          p_iready = 100, p_qready = 100, p_redir = 0;
    bit          redir_req = 0;
    logic [31:0] redir_target = '0;
    bit          release_rst = 0;
    int          f0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].addr ^ MASK;
            rsp_epoch      = pend[0].epoch;
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            rsp_epoch      = -1;
        end
        instr_ready    = ($urandom_range(99) < p_iready);
        imem_req_ready = ($urandom_range(99) < p_qready);
        if (redir_req) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            redir_req      = 0;
        end else if ($urandom_range(999) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
    endtask

    // Model: the queue holds every fetch accepted since the last flush, in program order.
    task automatic compare_cycle();
        bit e_req;
        bit e_iv;
        bit found;
        int due;
        e_req = !redirect_valid && (mq.size() < DEPTH);
        e_iv  = (mq.size() > 0) && mq[0].arrived;
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
        if (e_req) check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, e_iv});
        if (e_iv) begin
            check("instr", instr, mq[0].data);
            check("instr_pc", instr_pc, mq[0].pc);
        end
        if (imem_rsp_valid && !redirect_valid && rsp_epoch == epoch) begin
            found = 0;
            for (int k = 0; k < mq.size(); k++) begin
                if (!found && !mq[k].arrived) begin
                    mq[k].arrived = 1;
                    mq[k].data    = mq[k].pc ^ MASK;
                    found = 1;
                end
            end
            if (!found) begin
                n_fail++;
                $display("FAIL orphan_rsp cyc=%0d actual=response required=outstanding_fetch", cyc);
            end
        end
        if (e_iv && instr_ready) begin
            $display("instr cyc=%0d pc=%h data=%h", cyc, mq[0].pc, mq[0].data);
            void'(mq.pop_front());
        end
        if (e_req && imem_req_ready) begin
            mq.push_back('{pc: m_pc, data: 32'h0, arrived: 0});
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: imem_req_addr, epoch: epoch, due: due});
            m_pc = m_pc + 32'd4;
        end
        if (redirect_valid) begin
            mq.delete();
            epoch++;
            m_pc = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (release_rst) begin
            rst = 1'b0;
            release_rst = 0;
        end
        drive();
        @(negedge clk);
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) dut_fires++;
            compare_cycle();
        end
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redir_target = target;
        redir_req = 1;
        step();
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);

        // Streaming with a 1-cycle memory
        release_rst = 1;
        step();
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        step();
        step();
        check("first_instr_valid", {31'b0, instr_valid}, 32'd1);
        check("first_instr_pc", instr_pc, 32'h0);
        check("first_instr", instr, 32'hA5A5_0000);
        step();
        check("second_instr_pc", instr_pc, 32'h4);
        repeat (6) step();

        // Redirect coinciding with a handshake and a response
        do_redirect(32'h0000_0200);
        check("redir_hs_valid", {31'b0, instr_valid}, 32'd1);
        step();
        check("post_redir_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("post_redir_addr", imem_req_addr, 32'h200);
        repeat (8) step();

        // Downstream stall fills the buffer then stops requesting
        p_iready = 0;
        do_redirect(32'h0);
        f0 = dut_fires;
        repeat (10) step();
        check("stall_fires", dut_fires - f0, 32'd4);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("stall_instr_pc", instr_pc, 32'h0);
        check("stall_instr", instr, 32'hA5A5_0000);
        p_iready = 100;
        repeat (6) step();

        // Memory back-pressure holds the address
        p_qready = 0;
        do_redirect(32'h40);
        repeat (5) step();
        check("qstall_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("qstall_addr", imem_req_addr, 32'h40);
        p_qready = 100;
        repeat (8) step();

        // 3-cycle memory, redirect to a misaligned target with fetches in flight
        lat_min = 3;
        lat_max = 3;
        repeat (8) step();
        do_redirect(32'h103);
        step();
        check("redir103_addr", imem_req_addr, 32'h100);
        for (int k = 0; k < 30 && !instr_valid; k++) step();
        if (instr_valid) check("redir103_instr_pc", instr_pc, 32'h100);
        else begin
            n_fail++;
            $display("FAIL redir103_timeout cyc=%0d actual=no_instr required=instr_valid", cyc);
        end
        repeat (6) step();

        // Randomized traffic
        lat_min = 1;
        lat_max = 4;
        p_iready = 70;
        p_qready = 70;
        p_redir = 30;
        repeat (1500) step();

        // Reset mid-stream while an instruction is presented
        p_redir = 0;
        p_iready = 0;
        p_qready = 100;
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 20 && !instr_valid; k++) step();
        check("pre_rst_instr_valid", {31'b0, instr_valid}, 32'd1);
        @(posedge clk);
        cyc++;
        #3;
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("midrst_instr", instr, 32'd0);
        check("midrst_instr_pc", instr_pc, 32'd0);
        mq.delete();
        pend.delete();
        epoch++;
        m_pc = 32'h0;
        last_due = cyc;
        step();
        step();
        release_rst = 1;
        p_iready = 100;
        step();
        check("postrst_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("postrst_addr", imem_req_addr, 32'h0);
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
